// File: rtl/posit_pkg.sv
// Shared posit types for the regime decoder: raw posit word, decoded regime
// payload and the NaR test.
package posit_pkg;

  localparam int unsigned POSIT_N  = 16;
  localparam int unsigned POSIT_ES = 1;
  localparam int unsigned RUNW     = $clog2(POSIT_N);
  localparam int unsigned KW       = RUNW + 1;
  localparam int unsigned REMW     = POSIT_N - 1;

  typedef logic [POSIT_N-1:0] posit_t;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [KW-1:0] k;
    logic [RUNW-1:0]      run;
    logic                 term;
    logic [REMW-1:0]      rem;
  } regime_t;

  function automatic logic f_is_nar(input posit_t p);
    return p == {1'b1, {(POSIT_N-1){1'b0}}};
  endfunction

endpackage

// File: rtl/lead_run_tree.sv
// Leading-run counter: length of the run of bits equal to polarity_i starting at
// the MSB, built as a pairwise encode-and-merge tree. Saturates at W.
module lead_run_tree #(
  parameter  int unsigned W    = 15,
  localparam int unsigned CNTW = $clog2(W + 1)
) (
  input  logic [W-1:0]    bits_i,
  input  logic            polarity_i,
  output logic [CNTW-1:0] run_o
);

  localparam int unsigned LVL = $clog2(W);
  localparam int unsigned P   = 1 << LVL;
  localparam int unsigned CW  = LVL + 1;

  logic [P-1:0]  v_c;
  logic [P-1:0]  full_c;
  logic [CW-1:0] cnt_c [P];
  logic          fh_c;
  logic [CW-1:0] ch_c;
  logic [CW-1:0] cl_c;

  // Node 0 is the MSB side; padding bits never match, so the count stops at W.
  always_comb begin
    v_c  = '0;
    fh_c = 1'b0;
    ch_c = '0;
    cl_c = '0;
    v_c[P-1 -: W] = polarity_i ? bits_i : ~bits_i;
    for (int i = 0; i < int'(P); i++) begin
      full_c[i] = v_c[P-1-i];
      cnt_c[i]  = CW'(v_c[P-1-i]);
    end
    for (int l = 0; l < int'(LVL); l++) begin
      for (int i = 0; i < int'(P >> (l + 1)); i++) begin
        fh_c      = full_c[2*i];
        ch_c      = cnt_c[2*i];
        cl_c      = cnt_c[2*i+1];
        full_c[i] = fh_c & full_c[2*i+1];
        cnt_c[i]  = fh_c ? (CW'(1) << l) + cl_c : ch_c;
      end
    end
    run_o = CNTW'(cnt_c[0]);
  end

endmodule

// File: rtl/regime_decode_pipe.sv
// Three-stage posit regime decoder with per-stage valid/ready and collapsing bubbles:
// S1 flags + magnitude, S2 regime run count, S3 remainder shift + signed k.
module regime_decode_pipe
  import posit_pkg::*;
#(
  parameter  int unsigned N    = 16,
  parameter  int unsigned ES   = 1,
  localparam int unsigned RUNW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_posit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic                   out_zero,
  output logic                   out_nar,
  output logic signed [RUNW:0]   out_k,
  output logic [RUNW-1:0]        out_run,
  output logic                   out_term,
  output logic [N-2:0]           out_rem
);

  // The stage payload uses the package typedefs, so the widths must agree.
  if (N != POSIT_N || ES != POSIT_ES) begin : g_bad_param
    $error("regime_decode_pipe: N/ES must match posit_pkg");
  end

  logic rdy1_c, rdy2_c, rdy3_c;

  logic         vld1_q;
  logic         sign1_q, sign1_d;
  logic         zero1_q, zero1_d;
  logic         nar1_q, nar1_d;
  logic [N-2:0] field1_q, field1_d;

  logic         vld2_q;
  regime_t      part2_q, part2_d;
  logic [RUNW-1:0] run_c;

  logic         vld3_q;
  regime_t      out3_q, out3_d;

  assign rdy3_c   = !vld3_q || out_ready;
  assign rdy2_c   = !vld2_q || rdy3_c;
  assign rdy1_c   = !vld1_q || rdy2_c;
  assign in_ready = rdy1_c;

  // S1: special-value flags and regime field of the magnitude.
  always_comb begin
    sign1_d  = in_posit[N-1];
    zero1_d  = (in_posit == '0);
    nar1_d   = f_is_nar(posit_t'(in_posit));
    field1_d = '0;
    if (!zero1_d && !nar1_d)
      field1_d = (N-1)'(sign1_d ? (N)'(0) - in_posit : in_posit);
  end

  lead_run_tree #(.W(N-1)) u_run (
    .bits_i     (field1_q),
    .polarity_i (field1_q[N-2]),
    .run_o      (run_c)
  );

  // S2: run length and terminator; the unshifted field rides along in rem.
  always_comb begin
    part2_d      = '0;
    part2_d.sign = sign1_q;
    part2_d.zero = zero1_q;
    part2_d.nar  = nar1_q;
    if (!zero1_q && !nar1_q) begin
      part2_d.run  = run_c;
      part2_d.term = (run_c < RUNW'(N-1));
      part2_d.rem  = field1_q;
    end
  end

  // S3: the field MSB is the regime polarity b; drop regime + terminator.
  always_comb begin
    out3_d     = part2_q;
    out3_d.rem = part2_q.rem << (part2_q.run + RUNW'(part2_q.term));
    if (part2_q.rem[N-2])
      out3_d.k = KW'(part2_q.run) - KW'(1);
    else
      out3_d.k = -KW'(part2_q.run);
    if (part2_q.zero || part2_q.nar)
      out3_d.k = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q   <= 1'b0;
      sign1_q  <= 1'b0;
      zero1_q  <= 1'b0;
      nar1_q   <= 1'b0;
      field1_q <= '0;
      vld2_q   <= 1'b0;
      part2_q  <= '0;
      vld3_q   <= 1'b0;
      out3_q   <= '0;
    end else begin
      if (rdy1_c) vld1_q <= in_valid;
      if (rdy1_c && in_valid) begin
        sign1_q  <= sign1_d;
        zero1_q  <= zero1_d;
        nar1_q   <= nar1_d;
        field1_q <= field1_d;
      end
      if (rdy2_c) vld2_q <= vld1_q;
      if (rdy2_c && vld1_q) part2_q <= part2_d;
      if (rdy3_c) vld3_q <= vld2_q;
      if (rdy3_c && vld2_q) out3_q <= out3_d;
    end
  end

  assign out_valid = vld3_q;
  assign out_sign  = out3_q.sign;
  assign out_zero  = out3_q.zero;
  assign out_nar   = out3_q.nar;
  assign out_k     = out3_q.k;
  assign out_run   = out3_q.run;
  assign out_term  = out3_q.term;
  assign out_rem   = out3_q.rem;

endmodule

// File: tb/tb_regime_decode_pipe.sv
// Bench for regime_decode_pipe (N=16, ES=1): directed spec vectors, stall,
// mid-stream reset and randomized handshake traffic against a reference model.
module tb_regime_decode_pipe;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_posit;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic              out_zero;
  logic              out_nar;
  logic signed [4:0] out_k;
  logic [3:0]        out_run;
  logic              out_term;
  logic [14:0]       out_rem;

  int checks;
  int failures;
  logic [27:0] exp_q [$];

  regime_decode_pipe #(.N(16), .ES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_nar   (out_nar),
    .out_k     (out_k),
    .out_run   (out_run),
    .out_term  (out_term),
    .out_rem   (out_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode with integer arithmetic: {sign,zero,nar,k[5],run[4],term,rem[15]}.
  function automatic logic [27:0] model(input logic [15:0] p);
    int m, field, b, run, term, k, rem;
    logic s;
    s = p[15];
    if (p == 16'h0000) return {1'b0, 1'b1, 26'd0};
    if (p == 16'h8000) return {1'b1, 1'b0, 1'b1, 25'd0};
    m     = s ? (65536 - int'(p)) % 65536 : int'(p);
    field = m % 32768;
    b     = field / 16384;
    run   = 0;
    for (int i = 14; i >= 0; i--) begin
      if (((field >> i) & 1) == b) run++;
      else break;
    end
    term = (run < 15) ? 1 : 0;
    k    = (b == 1) ? run - 1 : -run;
    rem  = (field << (run + term)) % 32768;
    return {s, 1'b0, 1'b0, 5'(k), 4'(run), 1'(term), 15'(rem)};
  endfunction

  function automatic logic [27:0] obs();
    return {out_sign, out_zero, out_nar, out_k, out_run, out_term, out_rem};
  endfunction

  function automatic logic [15:0] pick_posit();
    int r;
    r = int'($urandom % 10);
    case (r)
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'h0001;
      4: return 16'h8001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [15:0] p);
    int lat;
    in_posit  = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_in_ready p=%h got=%b exp=1", p, in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL latency p=%h got=%0d exp=3", p, lat);
    end
    checks++;
    if (obs() !== model(p)) begin
      failures++;
      $display("FAIL decode p=%h got=%h exp=%h", p, obs(), model(p));
    end
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_posit  = 16'h0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (obs() !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", obs());
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] vec [6];
    vec = '{16'h5000, 16'h7FFF, 16'h0001, 16'hC000, 16'h0000, 16'h8000};
    for (int i = 0; i < 6; i++) send_one(vec[i]);
  endtask

  task automatic test_stall();
    logic [15:0] ps [5];
    logic [27:0] snap, e;
    bit          have_snap;
    int          idx, emitted;
    exp_q.delete();
    for (int i = 0; i < 5; i++) ps[i] = pick_posit();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx       = 0;
    have_snap = 1'b0;
    snap      = '0;
    for (int c = 0; c < 6; c++) begin
      in_posit = ps[idx];
      #1;
      if (out_valid === 1'b1) begin
        if (!have_snap) begin
          snap      = obs();
          have_snap = 1'b1;
        end else begin
          checks++;
          if (obs() !== snap) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=%h", obs(), snap);
          end
        end
      end
      if (in_ready === 1'b1) begin
        exp_q.push_back(model(ps[idx]));
        idx++;
      end
      tick();
    end
    #1;
    checks++;
    if (idx != 3) begin
      failures++;
      $display("FAIL stall_accepts got=%0d exp=3", idx);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if (snap !== model(ps[0])) begin
      failures++;
      $display("FAIL stall_first got=%h exp=%h", snap, model(ps[0]));
    end
    out_ready = 1'b1;
    emitted   = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 5) begin
        in_valid = 1'b1;
        in_posit = ps[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hFFFFFFF;
        checks++;
        if (obs() !== e) begin
          failures++;
          $display("FAIL stall_order n=%0d got=%h exp=%h", emitted, obs(), e);
        end
        emitted++;
      end else if (emitted > 0 && emitted < 5) begin
        checks++;
        failures++;
        $display("FAIL stall_gap after=%0d got=0 exp=1", emitted);
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(ps[idx]));
        idx++;
      end
      tick();
    end
    checks++;
    if (emitted != 5) begin
      failures++;
      $display("FAIL stall_count got=%0d exp=5", emitted);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_posit  = 16'h4800;
    tick();
    in_posit  = 16'h2345;
    tick();
    in_valid  = 1'b0;
    rst       = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out_valid got=%b exp=0", out_valid);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_ghost cycle=%0d got=%b exp=0", c, out_valid);
      end
    end
    send_one(16'h6C12);
  endtask

  task automatic test_random();
    logic [27:0] prev, e;
    bit          stalled_prev, hold;
    exp_q.delete();
    stalled_prev = 1'b0;
    hold         = 1'b0;
    prev         = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        in_valid = ($urandom % 10) < 7;
        in_posit = pick_posit();
      end
      out_ready = ($urandom % 10) < 6;
      #1;
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || obs() !== prev) begin
          failures++;
          $display("FAIL rand_hold cycle=%0d got=%h exp=%h", c, obs(), prev);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hFFFFFFF;
        checks++;
        if (obs() !== e) begin
          failures++;
          $display("FAIL rand_data cycle=%0d got=%h exp=%h", c, obs(), e);
        end
      end
      stalled_prev = (out_valid === 1'b1) && !out_ready;
      prev         = obs();
      if (in_valid && in_ready === 1'b1) exp_q.push_back(model(in_posit));
      hold = in_valid && (in_ready !== 1'b1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hFFFFFFF;
        checks++;
        if (obs() !== e) begin
          failures++;
          $display("FAIL drain_data got=%h exp=%h", obs(), e);
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_empty got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
